ts_meas_seq: RTL and testbench
==============================

TS_MEAS_SEQ -- requirements
Module: ts_meas_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: clk cycles per D2A_TS_CLK half-period (16 MHz / 50 = 320 kHz).
REQ-002 SHALL have parameter SETTLE_CYC, default 64: clk cycles from D2A_TS_EN rise to start pulse.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: maximum clk cycles waiting for one conversion.
REQ-004 SHALL have port clk, input, 1: 16 MHz oscillator clock.
REQ-005 SHALL have port RSTn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port FLOCK, input, 1: PLL lock; measurement permitted only while high.
REQ-007 SHALL have port meas_req, input, 1: level request; sampled in IDLE only.
REQ-008 SHALL have port cfg_npairs, input, 2: chopper pairs per result (0..3 -> 1, 2, 4, 8 pairs).
REQ-009 SHALL have port cfg_offset, input, 4: signed two's-complement trim added to the average.
REQ-010 SHALL have port A2D_TS_DETOK, input, 1: asynchronous conversion-done strobe.
REQ-011 SHALL have port A2D_TS_DOUT, input, 8: conversion code, stable while DETOK high.
REQ-012 SHALL have port D2A_TS_EN, output, 1: sensor enable.
REQ-013 SHALL have port D2A_TS_START_EN, output, 1: conversion-sequence start.
REQ-014 SHALL have port D2A_TS_CLK, output, 1: sensor conversion clock.
REQ-015 SHALL have port D2A_TS_CHOPPER_CLK, output, 1: chopper polarity.
REQ-016 SHALL have port res_data, output, 8: trimmed averaged temperature code.
REQ-017 SHALL have port res_valid, output, 1: result available; res_ready, input, 1: consumer accept.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE; err, output, 1: one-cycle error pulse; err_code, output, 1 (0 = timeout, 1 = lock loss).

Function
REQ-019 SHALL implement FSM states IDLE, SETTLE, START, CONV, ACCUM, DONE.
REQ-020 IDLE -> SETTLE when meas_req = 1 and FLOCK = 1; SHALL latch cfg_npairs and cfg_offset at this transition.
REQ-021 D2A_TS_EN SHALL be high in every state except IDLE; SETTLE SHALL last exactly SETTLE_CYC cycles.
REQ-022 In START, D2A_TS_START_EN SHALL be high for exactly 2*CLK_DIV cycles while D2A_TS_CLK is held low; the state then goes to CONV.
REQ-023 In CONV/ACCUM, D2A_TS_CLK SHALL toggle every CLK_DIV cycles, starting low; the divider SHALL reset on entry to CONV.
REQ-024 A2D_TS_DETOK SHALL be passed through a 2-flop synchronizer; a conversion completes on the synchronized rising edge.
REQ-025 On completion, A2D_TS_DOUT SHALL be captured; the state goes to ACCUM for one cycle and adds the sample to a 12-bit accumulator.
REQ-026 D2A_TS_CHOPPER_CLK SHALL be 0 for the first conversion of each pair and 1 for the second, toggling in ACCUM.
REQ-027 After ACCUM, the state SHALL return to CONV until 2*N samples have been taken (N = number of pairs); it then goes to DONE.
REQ-028 average = accumulator >> log2(2N), i.e. truncated; res_data = average + sign-extended cfg_offset, saturated to 0..255.
REQ-029 In DONE, res_valid SHALL be high and res_data stable until res_valid && res_ready; the state then goes to IDLE.
REQ-030 res_ready in the same cycle res_valid rises SHALL complete the transfer in that cycle.
REQ-031 If no completion occurs within TIMEOUT_CYC of CONV entry, the FSM SHALL go to IDLE with err = 1 and err_code = 0, and produce no result.
REQ-032 FLOCK low in SETTLE/START/CONV/ACCUM SHALL abort to IDLE with err = 1 and err_code = 1; FLOCK low in DONE SHALL NOT abort.
REQ-033 If timeout and lock loss occur in the same cycle, lock loss SHALL win.
REQ-034 A DETOK edge outside CONV SHALL be ignored; meas_req outside IDLE SHALL be ignored.

Reset
REQ-035 While RSTn is low, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the accumulator, counters and synchronizer SHALL be cleared.
REQ-036 Reset assertion mid-measurement SHALL drop D2A_TS_EN and res_valid immediately; err SHALL NOT pulse.

Structure
REQ-037 A shared package ts_pkg SHALL hold the FSM state enum, the err_code constants and the default parameter values.
REQ-038 The 320 kHz divider SHALL be sub-module ts_clk_div, with inputs enable and clear and output ts_clk.

Verification
REQ-039 cfg_npairs = 0, DOUT = 100 then 110, offset 0 -> res_data = 105, CHOPPER_CLK 0 then 1, one res_valid.
REQ-040 cfg_npairs = 3, 16 samples all 255, offset +7 -> res_data = 255 (saturated).
REQ-041 cfg_npairs = 0, samples 3 and 4, offset -8 -> res_data = 0 (saturated low).
REQ-042 No DETOK after start -> err pulse, err_code = 0, exactly TIMEOUT_CYC cycles after CONV entry; D2A_TS_EN = 0 the next cycle.
REQ-043 FLOCK dropped during CONV of the 2nd sample -> err_code = 1, no res_valid; a new meas_req then completes normally.
REQ-044 res_ready held low for 20 cycles in DONE -> res_data unchanged, meas_req ignored, release on the first ready cycle.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared types and constants for the temperature-sensor measurement sequencer.
// Latency: n/a (types, constants, and one combinational helper function).
// Backpressure: n/a.
package ts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_CONV,
        ST_ACCUM,
        ST_DONE
    } state_t;

    localparam logic ERR_TIMEOUT = 1'b0;
    localparam logic ERR_LOCK    = 1'b1;

    localparam int DEF_CLK_DIV     = 25;   // 16 MHz / (2*25) = 320 kHz
    localparam int DEF_SETTLE_CYC  = 64;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // Average plus signed 4-bit trim, clamped to the 8-bit code range.
    function automatic logic [7:0] trim_sat(input logic [11:0] avg, input logic [3:0] off);
        logic signed [13:0] sum;
        sum = signed'({2'b00, avg}) + signed'({{10{off[3]}}, off});
        if (sum < 0)
            return 8'd0;
        else if (sum > 14'sd255)
            return 8'd255;
        else
            return sum[7:0];
    endfunction

endpackage

// File: rtl/ts_meas_seq_if.sv
// Result channel of the measurement sequencer (valid/ready handshake).
// Latency: n/a (wiring only).
// Backpressure: res_data is held while res_valid is high and res_ready is low.
// Ports: res_data (8b code), res_valid (producer), res_ready (consumer).
interface ts_meas_seq_if;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;

    modport master (output res_data, output res_valid, input res_ready);
    modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/ts_clk_div.sv
// Sensor conversion clock divider: ts_clk toggles every DIV enabled cycles, starting low.
// Latency: first toggle DIV cycles after clear is released with enable high.
// Backpressure: none; clear has priority over enable.
// Ports: clk, RSTn, enable, clear, ts_clk.
module ts_clk_div #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic RSTn,
    input  logic enable,
    input  logic clear,
    output logic ts_clk
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt    <= '0;
            ts_clk <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            ts_clk <= 1'b0;
        end else if (enable) begin
            if (cnt == 16'(DIV - 1)) begin
                cnt    <= '0;
                ts_clk <= ~ts_clk;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ts_meas_seq.sv
// Temperature-sensor sequencer: settle, start, 2N chopped conversions, average + trim, result.
// Latency: SETTLE_CYC + 2*CLK_DIV cycles to first conversion; result one cycle after last sample.
// Backpressure: result held in DONE until res_valid && res_ready; new requests ignored meanwhile.
// Ports: clk, RSTn, FLOCK, meas_req, cfg_npairs, cfg_offset, A2D_TS_DETOK/DOUT in;
//        D2A_TS_EN/START_EN/CLK/CHOPPER_CLK out; res (result channel); busy, err, err_code.
module ts_meas_seq
    import ts_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       FLOCK,
    input  logic       meas_req,
    input  logic [1:0] cfg_npairs,
    input  logic [3:0] cfg_offset,
    input  logic       A2D_TS_DETOK,
    input  logic [7:0] A2D_TS_DOUT,
    output logic       D2A_TS_EN,
    output logic       D2A_TS_START_EN,
    output logic       D2A_TS_CLK,
    output logic       D2A_TS_CHOPPER_CLK,
    ts_meas_seq_if.master res,
    output logic       busy,
    output logic       err,
    output logic       err_code
);

    state_t      state, nxt;
    logic [15:0] cnt;
    logic        det_s1, det_s2, det_s3;
    logic        det_rise;
    logic [7:0]  sample;
    logic [11:0] acc, acc_next;
    logic [3:0]  nsamp;
    logic [4:0]  nsamp_tgt;
    logic        last_sample;
    logic [1:0]  npairs_q;
    logic [3:0]  offset_q;
    logic        chop;
    logic [7:0]  res_q;
    logic        err_set, err_code_set;
    logic        lock_abort;
    logic        in_conv;

    // det_s3 is only the edge-detect history; the synchronizer proper is s1/s2.
    assign det_rise    = det_s2 & ~det_s3;
    assign acc_next    = acc + {4'd0, sample};
    assign nsamp_tgt   = 5'd2 << npairs_q;
    assign last_sample = (({1'b0, nsamp} + 5'd1) == nsamp_tgt);
    assign in_conv     = (state == ST_CONV) || (state == ST_ACCUM);
    assign lock_abort  = !FLOCK && (state inside {ST_SETTLE, ST_START, ST_CONV, ST_ACCUM});

    always_comb begin
        nxt          = state;
        err_set      = 1'b0;
        err_code_set = ERR_TIMEOUT;
        case (state)
            ST_IDLE:   if (meas_req && FLOCK) nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == 16'(SETTLE_CYC - 1)) nxt = ST_START;
            ST_START:  if (cnt == 16'(2 * CLK_DIV - 1)) nxt = ST_CONV;
            ST_CONV: begin
                // A completion in the final timeout cycle still counts as in time.
                if (det_rise) begin
                    nxt = ST_ACCUM;
                end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
                    nxt     = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_ACCUM:  nxt = last_sample ? ST_DONE : ST_CONV;
            ST_DONE:   if (res.res_ready) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        // Lock loss overrides everything, including a coincident timeout.
        if (lock_abort) begin
            nxt          = ST_IDLE;
            err_set      = 1'b1;
            err_code_set = ERR_LOCK;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            det_s1   <= 1'b0;
            det_s2   <= 1'b0;
            det_s3   <= 1'b0;
            sample   <= '0;
            acc      <= '0;
            nsamp    <= '0;
            npairs_q <= '0;
            offset_q <= '0;
            chop     <= 1'b0;
            res_q    <= '0;
            err      <= 1'b0;
            err_code <= 1'b0;
        end else begin
            state  <= nxt;
            // Per-state cycle counter: restarts on every state change, so each
            // CONV entry (including from ACCUM) restarts the timeout window.
            cnt    <= (nxt != state) ? 16'd0 : cnt + 16'd1;
            det_s1 <= A2D_TS_DETOK;
            det_s2 <= det_s1;
            det_s3 <= det_s2;
            err    <= err_set;
            if (err_set)
                err_code <= err_code_set;

            if (state == ST_IDLE) begin
                chop <= 1'b0;
                if (nxt == ST_SETTLE) begin
                    npairs_q <= cfg_npairs;
                    offset_q <= cfg_offset;
                    acc      <= '0;
                    nsamp    <= '0;
                end
            end

            if (state == ST_CONV && det_rise)
                sample <= A2D_TS_DOUT;

            if (state == ST_ACCUM) begin
                acc   <= acc_next;
                nsamp <= nsamp + 4'd1;
                chop  <= ~chop;
                if (last_sample)
                    res_q <= trim_sat(acc_next >> ({1'b0, npairs_q} + 3'd1), offset_q);
            end
        end
    end

    // The divider runs continuously across CONV/ACCUM so the sensor clock never
    // glitches between conversions; it is cleared everywhere else.
    ts_clk_div #(.DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .RSTn   (RSTn),
        .enable (in_conv),
        .clear  (!in_conv),
        .ts_clk (D2A_TS_CLK)
    );

    assign D2A_TS_EN          = (state != ST_IDLE);
    assign D2A_TS_START_EN    = (state == ST_START);
    assign D2A_TS_CHOPPER_CLK = chop;
    assign busy               = (state != ST_IDLE);
    assign res.res_valid      = (state == ST_DONE);
    assign res.res_data       = res_q;

endmodule

// File: tb/tb_ts_meas_seq.sv
// Directed testbench for ts_meas_seq with hand-computed expected results.
// Latency: n/a.
// Backpressure: exercises res_ready held low in DONE.
module tb_ts_meas_seq;

    localparam int CLK_DIV     = 4;
    localparam int SETTLE_CYC  = 10;
    localparam int TIMEOUT_CYC = 200;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       FLOCK;
    logic       meas_req;
    logic [1:0] cfg_npairs;
    logic [3:0] cfg_offset;
    logic       A2D_TS_DETOK;
    logic [7:0] A2D_TS_DOUT;
    logic       D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK;
    logic       busy, err, err_code;

    ts_meas_seq_if rif();

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    int valid_cyc = 0;
    int err_seen = 0;
    logic [7:0] last_res = '0;

    always #5 clk = ~clk;

    ts_meas_seq #(
        .CLK_DIV(CLK_DIV), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .RSTn(RSTn), .FLOCK(FLOCK), .meas_req(meas_req),
        .cfg_npairs(cfg_npairs), .cfg_offset(cfg_offset),
        .A2D_TS_DETOK(A2D_TS_DETOK), .A2D_TS_DOUT(A2D_TS_DOUT),
        .D2A_TS_EN(D2A_TS_EN), .D2A_TS_START_EN(D2A_TS_START_EN),
        .D2A_TS_CLK(D2A_TS_CLK), .D2A_TS_CHOPPER_CLK(D2A_TS_CHOPPER_CLK),
        .res(rif.master), .busy(busy), .err(err), .err_code(err_code)
    );

    // Observers on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rif.res_valid) valid_cyc++;
        if (rif.res_valid && rif.res_ready) begin
            xfer_cnt++;
            last_res = rif.res_data;
        end
        if (err) err_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request and runs until the first CONV cycle, reporting phase lengths.
    task automatic begin_meas(input logic [1:0] np, input logic [3:0] off,
                              output int settle_n, output int start_n, output int clk_hi);
        int g;
        settle_n = 0; start_n = 0; clk_hi = 0; g = 0;
        cfg_npairs = np;
        cfg_offset = off;
        meas_req   = 1'b1;
        tick();
        meas_req   = 1'b0;
        cfg_npairs = ~np;          // must not affect the latched configuration
        cfg_offset = ~off;
        while (D2A_TS_EN && !D2A_TS_START_EN && g < 1000) begin
            settle_n++; g++; tick();
        end
        while (D2A_TS_START_EN && g < 1000) begin
            start_n++; g++;
            if (D2A_TS_CLK) clk_hi++;
            tick();
        end
    endtask

    // One conversion: wait in CONV, report chopper, pulse DETOK with data.
    task automatic conv(input logic [7:0] d, output logic chop_seen);
        repeat (3) tick();
        chop_seen    = D2A_TS_CHOPPER_CLK;
        A2D_TS_DOUT  = d;
        A2D_TS_DETOK = 1'b1;
        repeat (5) tick();
        A2D_TS_DETOK = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; FLOCK = 1'b1; meas_req = 1'b1; cfg_npairs = 2'd0; cfg_offset = 4'd0;
        A2D_TS_DETOK = 1'b0; A2D_TS_DOUT = 8'd0; rif.res_ready = 1'b1;
        repeat (3) tick();
        checks++; if (D2A_TS_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", D2A_TS_EN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rif.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rif.res_valid); end
        checks++; if (rif.res_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", rif.res_data); end
        checks++; if ({err, err_code, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK} !== 5'b0)
            begin errors++; $display("FAIL reset_misc: got %b expected 00000",
                {err, err_code, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK}); end
        meas_req = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int s, st, hi, x0, v0;
        logic c0, c1;
        x0 = xfer_cnt; v0 = valid_cyc;
        begin_meas(2'd0, 4'd0, s, st, hi);
        checks++; if (s !== SETTLE_CYC) begin errors++; $display("FAIL settle_len: got %0d expected %0d", s, SETTLE_CYC); end
        checks++; if (st !== 2 * CLK_DIV) begin errors++; $display("FAIL start_len: got %0d expected %0d", st, 2 * CLK_DIV); end
        checks++; if (hi !== 0) begin errors++; $display("FAIL start_clk_low: got %0d high cycles expected 0", hi); end
        repeat (3) tick();
        checks++; if (D2A_TS_CLK !== 1'b0) begin errors++; $display("FAIL div_low: got %b expected 0", D2A_TS_CLK); end
        tick();
        checks++; if (D2A_TS_CLK !== 1'b1) begin errors++; $display("FAIL div_toggle: got %b expected 1", D2A_TS_CLK); end
        conv(8'd100, c0);
        conv(8'd110, c1);
        tick();
        checks++; if ({c0, c1} !== 2'b01) begin errors++; $display("FAIL chopper: got %b expected 01", {c0, c1}); end
        checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL basic_xfers: got %0d expected 1", xfer_cnt - x0); end
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cyc - v0); end
        checks++; if (last_res !== 8'd105) begin errors++; $display("FAIL basic_result: got %0d expected 105", last_res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy); end
    endtask

    task automatic test_trim();
        int s, st, hi;
        logic c;
        // (10+20+30+41)=101 >> 2 = 25, offset -3 -> 22
        begin_meas(2'd1, 4'hD, s, st, hi);
        conv(8'd10, c); conv(8'd20, c); conv(8'd30, c); conv(8'd41, c);
        tick();
        checks++; if (last_res !== 8'd22) begin errors++; $display("FAIL trim_result: got %0d expected 22", last_res); end
    endtask

    task automatic test_sat_high();
        int s, st, hi;
        logic c;
        begin_meas(2'd3, 4'd7, s, st, hi);
        for (int i = 0; i < 16; i++) conv(8'd255, c);
        tick();
        checks++; if (last_res !== 8'd255) begin errors++; $display("FAIL sat_high: got %0d expected 255", last_res); end
    endtask

    task automatic test_sat_low();
        int s, st, hi;
        logic c;
        begin_meas(2'd0, 4'h8, s, st, hi);
        conv(8'd3, c); conv(8'd4, c);
        tick();
        checks++; if (last_res !== 8'd0) begin errors++; $display("FAIL sat_low: got %0d expected 0", last_res); end
    endtask

    task automatic test_timeout();
        int s, st, hi, n, x0;
        x0 = xfer_cnt; n = 0;
        begin_meas(2'd0, 4'd0, s, st, hi);
        while (!err && n < TIMEOUT_CYC + 50) begin tick(); n++; end
        checks++; if (n !== TIMEOUT_CYC) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT_CYC); end
        checks++; if (err_code !== 1'b0) begin errors++; $display("FAIL timeout_code: got %b expected 0", err_code); end
        tick();
        checks++; if ({err, D2A_TS_EN} !== 2'b00) begin errors++; $display("FAIL timeout_after: got err,en=%b expected 00", {err, D2A_TS_EN}); end
        checks++; if (xfer_cnt !== x0) begin errors++; $display("FAIL timeout_no_result: got %0d expected %0d", xfer_cnt, x0); end
    endtask

    task automatic test_lock_loss();
        int s, st, hi, x0, v0;
        logic c;
        x0 = xfer_cnt; v0 = valid_cyc;
        begin_meas(2'd0, 4'd0, s, st, hi);
        conv(8'd70, c);
        repeat (2) tick();
        FLOCK = 1'b0;
        tick();
        checks++; if ({err, err_code, D2A_TS_EN} !== 3'b110) begin errors++; $display("FAIL lock_abort: got err,code,en=%b expected 110", {err, err_code, D2A_TS_EN}); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_err_pulse: got %b expected 0", err); end
        checks++; if (valid_cyc !== v0) begin errors++; $display("FAIL lock_no_valid: got %0d expected %0d", valid_cyc, v0); end
        FLOCK = 1'b1;
        begin_meas(2'd0, 4'd0, s, st, hi);
        conv(8'd50, c); conv(8'd60, c);
        tick();
        checks++; if (xfer_cnt - x0 !== 1 || last_res !== 8'd55) begin errors++;
            $display("FAIL lock_recover: got xfers=%0d res=%0d expected 1 and 55", xfer_cnt - x0, last_res); end
    endtask

    task automatic test_back_pressure();
        int s, st, hi, x0;
        logic c;
        x0 = xfer_cnt;
        rif.res_ready = 1'b0;
        // (200+201)=401 >> 1 = 200, offset +1 -> 201
        begin_meas(2'd0, 4'd1, s, st, hi);
        conv(8'd200, c); conv(8'd201, c);
        checks++; if (rif.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", rif.res_valid); end
        meas_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (rif.res_data !== 8'd201 || rif.res_valid !== 1'b1) begin errors++;
                $display("FAIL bp_hold_%0d: got data=%0d valid=%b expected 201 and 1", i, rif.res_data, rif.res_valid); end
        end
        meas_req = 1'b0;
        rif.res_ready = 1'b1;
        tick();
        checks++; if ({rif.res_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got valid,busy=%b expected 00", {rif.res_valid, busy}); end
        checks++; if (xfer_cnt - x0 !== 1 || last_res !== 8'd201) begin errors++;
            $display("FAIL bp_xfer: got xfers=%0d res=%0d expected 1 and 201", xfer_cnt - x0, last_res); end
    endtask

    task automatic test_mid_reset();
        int s, st, hi, e0;
        logic c;
        e0 = err_seen;
        begin_meas(2'd1, 4'd0, s, st, hi);
        conv(8'd9, c);
        tick();
        RSTn = 1'b0;
        #1;
        checks++; if ({D2A_TS_EN, rif.res_valid, busy} !== 3'b000) begin errors++;
            $display("FAIL midreset_outputs: got en,valid,busy=%b expected 000", {D2A_TS_EN, rif.res_valid, busy}); end
        repeat (3) tick();
        RSTn = 1'b1;
        repeat (2) tick();
        checks++; if (err_seen !== e0) begin errors++; $display("FAIL midreset_no_err: got %0d expected %0d", err_seen, e0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trim();
        test_sat_high();
        test_sat_low();
        test_timeout();
        test_lock_loss();
        test_back_pressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
